// File: rtl/act_out_collector.sv
// -----------------------------------------------------------------------------
// act_out_collector
//
// Collects the wide activation words a pointwise conv layer emits on its
// single-cycle ready strobe. It buffers them in a small circular FIFO and
// re-streams each word as RATIO = IN_W/OUT_W narrower beats, lowest slice
// first, under a valid/ready handshake. The upstream layer cannot be stalled,
// so a word that arrives when there is no room is dropped and recorded in a
// sticky overflow flag.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   capture strobe (the conv layer's ready)
//   in_act     in   IN_W-bit activation word, channel k in bits [8k+7:8k]
//   out_valid  out  a beat is presented
//   out_ready  in   downstream accepts the beat
//   out_act    out  OUT_W-bit current beat (zero while empty)
//   out_last   out  current beat is the final slice of its word
//   level      out  words held, including a partially sent one
//   overflow   out  sticky: at least one word was dropped
// -----------------------------------------------------------------------------
module act_out_collector #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [IN_W-1:0]            in_act,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_act,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int RATIO  = IN_W / OUT_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  // Word storage; data only, so it carries no reset.
  logic [IN_W-1:0]   mem [DEPTH];

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  cnt;
  logic [BEAT_W-1:0] beat;

  logic              xfer;
  logic              pop;
  logic              wr;
  logic              drop;
  logic [IN_W-1:0]   head;

  assign out_valid = (cnt != '0);
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (beat == LAST_BEAT);

  // A full FIFO still takes a word when the head word leaves on the same edge;
  // pointers are power-of-two sized so the slot being freed is the one wp hits.
  assign wr   = in_valid & ((cnt != FULL) | pop);
  assign drop = in_valid & ~wr;

  assign head     = mem[rp];
  assign out_act  = out_valid ? head[beat*OUT_W +: OUT_W] : '0;
  assign out_last = out_valid & (beat == LAST_BEAT);
  assign level    = cnt;

  // Capture stage: the write never targets rp while a word is still being sent,
  // because a full FIFO only writes on the edge that retires the head word.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp] <= in_act;
    end
  end

  // Control stage: pointers, occupancy, beat index and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wp <= wp + 1'b1;
      end

      if (xfer) begin
        if (beat == LAST_BEAT) begin
          beat <= '0;
          rp   <= rp + 1'b1;
        end else begin
          beat <= beat + 1'b1;
        end
      end

      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_act_out_collector.sv
// -----------------------------------------------------------------------------
// Testbench for act_out_collector: directed scenarios followed by random
// traffic. A queue-based reference model predicts accepted words and the beats
// they produce; a monitor on the falling edge pops and compares each beat.
// -----------------------------------------------------------------------------
module tb_act_out_collector;

  localparam int IN_W  = 128;
  localparam int OUT_W = 64;
  localparam int DEPTH = 4;
  localparam int RATIO = IN_W / OUT_W;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic [IN_W-1:0]            in_act;
  logic                       out_valid;
  logic                       out_ready;
  logic [OUT_W-1:0]           out_act;
  logic                       out_last;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic                       overflow;

  always #5 clk = ~clk;

  act_out_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_act    (in_act),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t           exp_q[$];
  logic [IN_W-1:0] words[$];
  int              sent = 0;
  bit              ov_m = 1'b0;
  int              n_chk = 0;
  int              n_fail = 0;
  beat_t           e;

  localparam logic [IN_W-1:0] W_BYTES = 128'h0F0E0D0C0B0A09080706050403020100;

  task automatic chk(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then check the state the
  // DUT should hold after the edge.
  task automatic step(input bit iv, input logic [IN_W-1:0] w, input bit rdy);
    bit    xf, pp, acc;
    beat_t b;
    in_valid  = iv;
    in_act    = iv ? w : {$urandom, $urandom, $urandom, $urandom};
    out_ready = rdy;
    xf  = rdy && (words.size() > 0);
    pp  = xf && (sent == RATIO - 1);
    acc = iv && ((words.size() < DEPTH) || pp);
    if (xf) begin
      if (pp) begin
        void'(words.pop_front());
        sent = 0;
      end else begin
        sent++;
      end
    end
    if (acc) begin
      words.push_back(w);
      for (int k = 0; k < RATIO; k++) begin
        b.data = w[k*OUT_W +: OUT_W];
        b.last = (k == RATIO - 1);
        exp_q.push_back(b);
      end
    end
    if (iv && !acc) ov_m = 1'b1;
    @(posedge clk);
    #1;
    chk("level", level, words.size());
    chk("overflow", overflow, ov_m);
    chk("out_valid", out_valid, words.size() != 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && words.size() > 0; i++) step(1'b0, '0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_act", out_act, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    words.delete();
    exp_q.delete();
    sent = 0;
    ov_m = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Beat monitor: every transfer must match the next predicted beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL beat_unexpected: got %0h expected no beat", out_act);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_act, e.data);
          chk("beat_last", out_last, e.last);
        end
      end
      if (!out_valid) chk("idle_outputs", {out_act, out_last}, '0);
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_act    = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single word, two beats in order.
    step(1'b1, W_BYTES, 1'b1);
    chk("t1_beat0", out_act, 64'h0706050403020100);
    chk("t1_last0", out_last, 0);
    step(1'b0, '0, 1'b1);
    chk("t1_beat1", out_act, 64'h0F0E0D0C0B0A0908);
    chk("t1_last1", out_last, 1);
    step(1'b0, '0, 1'b1);

    // Backpressure hold.
    step(1'b1, W_BYTES, 1'b0);
    repeat (5) begin
      step(1'b0, '0, 1'b0);
      chk("t2_hold", out_act, 64'h0706050403020100);
    end
    drain();

    // Fill and overflow.
    for (int v = 1; v <= 5; v++) step(1'b1, IN_W'(v), 1'b0);
    chk("t3_level", level, DEPTH);
    chk("t3_ovf", overflow, 1);
    drain();
    chk("t3_ovf_sticky", overflow, 1);

    // Full FIFO write coinciding with a final beat.
    do_reset();
    for (int v = 1; v <= 4; v++) step(1'b1, IN_W'(v), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, IN_W'(9), 1'b1);
    chk("t4_level", level, DEPTH);
    chk("t4_ovf", overflow, 0);
    drain();

    // Back-to-back writes while draining.
    for (int v = 1; v <= 8; v++) step(1'b1, IN_W'(v), 1'b1);
    drain();
    chk("t5_ovf", overflow, 1);

    // Reset in the middle of a word.
    do_reset();
    for (int v = 1; v <= 3; v++) step(1'b1, {32'h5A5A5A5A, 96'(v)}, 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b1, IN_W'(8'hAA), 1'b1);
    drain();

    // Random traffic.
    do_reset();
    repeat (400) begin
      step($urandom_range(0, 99) < 40, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 99) < 60);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
